// File: rtl/acc_pkg.sv
// Shared defaults and FSM encoding for the accelerator write-back path.
package acc_pkg;

    localparam int unsigned SUM_W_DEF      = 20;
    localparam int unsigned ADDR_W_DEF     = 13;
    localparam int unsigned RESULT_CNT_DEF = 32;
    localparam int unsigned DEPTH_DEF      = 4;
    localparam int unsigned BASE_ADDR_DEF  = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } wb_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO, DEPTH x WIDTH, wrap-bit pointers, show-ahead head.
module sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 20
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    // A pop frees a slot in the same cycle, so push on full is fine when popping.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Storage array write.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

    // Pointer update with synchronous flush.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

endmodule

// File: rtl/wb_queue.sv
// Write-back queue: buffers ALU sums, writes them sign-extended to the result
// RAM whenever the APB side is not using the port, and tracks frame completion.
module wb_queue
    import acc_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned SUM_W      = SUM_W_DEF,
    parameter int unsigned DEPTH      = DEPTH_DEF,
    parameter int unsigned RESULT_CNT = RESULT_CNT_DEF,
    parameter int unsigned BASE_ADDR  = BASE_ADDR_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              sum_valid,
    input  logic [SUM_W-1:0]  sum,
    input  logic              rd_req,
    input  logic              ram_ry,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              full,
    output logic              empty,
    output logic              wb_done,
    output logic              overflow
);

    localparam int unsigned       CNT_W    = $clog2(RESULT_CNT + 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(RESULT_CNT - 1);

    wb_state_e         state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [31:0]       ram_wdata_q;
    logic              done_q;
    logic              ovf_q;

    logic              flush;
    logic              push;
    logic              pop;
    logic              drop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [SUM_W-1:0]  head;

    assign flush = rst | clear;

    // Arbitration: pops only in RUN and only when APB and RAM allow it.
    always_comb begin
        pop  = !fifo_empty && !rd_req && ram_ry && (state_q == RUN);
        push = sum_valid && !clear && (state_q != DONE) && (!fifo_full || pop);
        drop = sum_valid && !clear && !push;
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SUM_W)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (flush),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (sum),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Frame FSM, counters and registered RAM write port.
    always_ff @(posedge clk) begin
        if (flush) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= BASE;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= BASE;
            ram_wdata_q <= '0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            ram_we_q <= pop;
            if (drop) ovf_q <= 1'b1;
            case (state_q)
                IDLE: if (sum_valid) state_q <= RUN;
                RUN: begin
                    if (pop && (cnt_q == LAST_IDX)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE:    state_q <= DONE;
                default: state_q <= IDLE;
            endcase
            if (pop) begin
                ram_addr_q  <= addr_q;
                ram_wdata_q <= {{(32 - SUM_W){head[SUM_W-1]}}, head};
                addr_q      <= addr_q + 1'b1;
                cnt_q       <= cnt_q + 1'b1;
            end
        end
    end

    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign full      = fifo_full;
    assign empty     = fifo_empty;
    assign wb_done   = done_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_wb_queue.sv
// Randomized scoreboard bench for wb_queue against a queue-based frame model.
module tb_wb_queue;

    localparam int unsigned ADDR_W = 13;
    localparam int unsigned SUM_W  = 20;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned RCNT   = 32;
    localparam int unsigned BASE   = 0;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clear = 1'b0;
    logic              sum_valid = 1'b0;
    logic [SUM_W-1:0]  sum = '0;
    logic              rd_req = 1'b0;
    logic              ram_ry = 1'b1;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic              full;
    logic              empty;
    logic              wb_done;
    logic              overflow;

    wb_queue #(
        .ADDR_W     (ADDR_W),
        .SUM_W      (SUM_W),
        .DEPTH      (DEPTH),
        .RESULT_CNT (RCNT),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .sum_valid (sum_valid),
        .sum       (sum),
        .rd_req    (rd_req),
        .ram_ry    (ram_ry),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .full      (full),
        .empty     (empty),
        .wb_done   (wb_done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned addr;
        logic [31:0] data;
        bit          done;
    } exp_t;

    exp_t sb[$];

    // Reference model: pending results, frame progress, sticky flags.
    int unsigned mq[$];
    bit          m_started = 0;
    bit          m_done = 0;
    bit          m_ovf = 0;
    int unsigned m_written = 0;
    int unsigned m_next_addr = BASE;
    int unsigned m_last_addr = BASE;
    bit          armed = 0;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] sext(input logic [SUM_W-1:0] s);
        longint v;
        v = longint'(s);
        if (v >= (longint'(1) << (SUM_W - 1))) v = v - (longint'(1) << SUM_W);
        return 32'(v);
    endfunction

    // Advance the model by one clock edge using the inputs the DUT sampled.
    task automatic model_edge();
        bit   was_done;
        bit   do_pop;
        exp_t e;
        armed = 1;
        if (rst || clear) begin
            mq.delete();
            m_started = 0;
            m_done = 0;
            m_ovf = 0;
            m_written = 0;
            m_next_addr = BASE;
            m_last_addr = BASE;
            return;
        end
        was_done = m_done;
        do_pop = (mq.size() > 0) && m_started && !m_done && !rd_req && ram_ry;
        if (do_pop) begin
            e.addr = m_next_addr;
            e.data = sext(SUM_W'(mq.pop_front()));
            m_written++;
            e.done = (m_written == RCNT);
            sb.push_back(e);
            m_last_addr = m_next_addr;
            m_next_addr = (m_next_addr + 1) % (1 << ADDR_W);
            if (m_written == RCNT) begin
                m_done = 1;
                m_started = 0;
            end
        end
        if (sum_valid) begin
            if (was_done || (mq.size() >= DEPTH)) m_ovf = 1;
            else begin
                mq.push_back(int'(sum));
                if (!was_done) m_started = 1;
            end
        end
    endtask

    task automatic step(input logic r, input logic c, input logic v,
                        input logic [SUM_W-1:0] s, input logic rq, input logic ry);
        rst = r; clear = c; sum_valid = v; sum = s; rd_req = rq; ram_ry = ry;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Monitor: compare every write against the scoreboard and the flags against the model.
    always @(negedge clk) begin
        exp_t e;
        if (armed) begin
            if (ram_we) begin
                if (sb.size() == 0) begin
                    chk("unexpected_write", 32'(ram_addr), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("wr_addr", 32'(ram_addr), e.addr);
                    chk("wr_data", ram_wdata, e.data);
                    chk("wr_done", 32'(wb_done), 32'(e.done));
                end
            end else if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("missing_write_we", 32'(ram_we), 32'd1);
            end
            chk("ram_addr", 32'(ram_addr), m_last_addr);
            chk("full", 32'(full), 32'(mq.size() == DEPTH));
            chk("empty", 32'(empty), 32'(mq.size() == 0));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("wb_done", 32'(wb_done), 32'(m_done));
        end
    end

    int rq_left;

    initial begin
        // Reset, then a single positive result and a single negative one.
        step(1, 0, 0, '0, 0, 1);
        step(1, 0, 0, '0, 0, 1);
        chk("reset_we", 32'(ram_we), 32'd0);
        chk("reset_wdata", ram_wdata, 32'd0);
        step(0, 0, 1, 20'h00005, 0, 1);
        step(0, 0, 0, '0, 0, 1);
        chk("first_write_data", ram_wdata, 32'h0000_0005);
        step(0, 0, 1, 20'h80000, 0, 1);
        step(0, 0, 0, '0, 0, 1);
        chk("neg_write_data", ram_wdata, 32'hFFF8_0000);
        step(0, 0, 1, 20'hFFFFE, 0, 1);
        step(0, 0, 0, '0, 0, 1);
        chk("neg2_write_data", ram_wdata, 32'hFFFF_FFFE);

        // Stall for 6 cycles with 5 back-to-back results: 5th is dropped.
        step(0, 1, 0, '0, 0, 1);
        for (int i = 0; i < 6; i++)
            step(0, 0, (i < 5), SUM_W'(100 + i), 1, 1);
        chk("stall_overflow", 32'(overflow), 32'd1);
        for (int i = 0; i < 6; i++) step(0, 0, 0, '0, 0, 1);

        // Full frame with no stalls, then a 33rd result.
        step(0, 1, 0, '0, 0, 1);
        for (int i = 0; i < RCNT; i++)
            step(0, 0, 1, SUM_W'($urandom), 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, '0, 0, 1);
        chk("frame_done", 32'(wb_done), 32'd1);
        step(0, 0, 1, 20'h12345, 0, 1);
        step(0, 0, 0, '0, 0, 1);
        chk("post_done_overflow", 32'(overflow), 32'd1);

        // Clear restarts at BASE.
        step(0, 1, 0, '0, 0, 1);
        chk("clear_done", 32'(wb_done), 32'd0);
        chk("clear_addr", 32'(ram_addr), BASE);
        step(0, 0, 1, 20'h00042, 0, 1);
        step(0, 0, 0, '0, 0, 1);

        // Reset mid-frame with 3 queued entries.
        for (int i = 0; i < 3; i++) step(0, 0, 1, SUM_W'(7 + i), 1, 1);
        step(1, 0, 0, '0, 0, 1);
        chk("rst_mid_empty", 32'(empty), 32'd1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, '0, 0, 1);

        // Randomized traffic with stall bursts, occasional clear and reset.
        rq_left = 0;
        for (int i = 0; i < 3000; i++) begin
            logic r, c, v, rq, ry;
            r = ($urandom_range(0, 999) == 0);
            c = ($urandom_range(0, 199) == 0) || (m_done && ($urandom_range(0, 15) == 0));
            v = ($urandom_range(0, 99) < 55);
            if (rq_left == 0 && $urandom_range(0, 99) < 8) rq_left = $urandom_range(1, 8);
            rq = (rq_left > 0);
            if (rq_left > 0) rq_left--;
            ry = ($urandom_range(0, 99) < 90);
            step(r, c, v, SUM_W'($urandom), rq, ry);
        end
        for (int i = 0; i < 8; i++) step(0, 0, 0, '0, 0, 1);
        @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
